// File: rtl/line_buffer_2bank_pkg.sv
// line_buffer_2bank_pkg
// Shared helpers for the two-bank line buffer.
//   is_transparent : 1 when the low nbits of a pixel are all zero and nbits
//                    is non-zero, i.e. the pixel must not be written.
package line_buffer_2bank_pkg;

    // A pixel whose low nbits are all zero is treated as transparent.
    // nbits == 0 turns transparency off.
    function automatic logic is_transparent(input logic [63:0] data, input int nbits);
        logic any_set;
        any_set = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((i < nbits) && data[i]) begin
                any_set = 1'b1;
            end
        end
        return (nbits != 0) && !any_set;
    endfunction

endpackage

// File: rtl/line_buffer_2bank_dpram.sv
// dpram
// Simple dual-port RAM, one clock, 2^AW x DW words, contents never reset.
//   clk             : clock
//   a_we/a_addr/a_wdata          : port A, write only
//   b_en/b_we/b_addr/b_wdata     : port B, read with optional write-back
//   b_rdata         : port B read data, one cycle after b_en, read-first
module dpram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Read data holds its last value unless port B is enabled.
    always_comb begin
        rdata_d = rdata_q;
        if (b_en) begin
            rdata_d = mem[b_addr];
        end
    end

    // Port B read samples the old word, so a write-back in the same cycle
    // (clear-on-read) does not disturb the returned data.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

    assign b_rdata = rdata_q;

endmodule

// File: rtl/line_buffer_2bank.sv
// line_buffer_2bank
// Ping-pong line buffer: one bank is filled while the other is read out,
// banks are exchanged on I_SWAP. After reset both banks are swept to CLR_VAL.
//   I_CLK, I_RST          : clock, synchronous active-high reset
//   I_SWAP                : exchange write and read banks
//   I_WE, I_WADDR, I_WD   : write into bank O_WBANK (transparent pixels dropped)
//   I_RE, I_RADDR         : read from bank ~O_WBANK, optional clear-on-read
//   O_RD, O_RVALID        : read data one cycle after I_RE, zero when not valid
//   O_WBANK               : current write bank
//   O_READY               : initial clear sweep has finished
module line_buffer_2bank
    import line_buffer_2bank_pkg::*;
#(
    parameter int            AW            = 9,
    parameter int            DW            = 8,
    parameter bit            CLEAR_ON_READ = 1'b1,
    parameter logic [DW-1:0] CLR_VAL       = '0,
    parameter int            TRANSP_BITS   = 2
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_SWAP,
    input  logic          I_WE,
    input  logic [AW-1:0] I_WADDR,
    input  logic [DW-1:0] I_WD,
    input  logic          I_RE,
    input  logic [AW-1:0] I_RADDR,
    output logic [DW-1:0] O_RD,
    output logic          O_RVALID,
    output logic          O_WBANK,
    output logic          O_READY
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   sweep_q, sweep_d;
    logic          wbank_q, wbank_d;
    logic          ready_q, ready_d;
    logic          rvalid_q, rvalid_d;
    logic          rd_bank_q, rd_bank_d;

    logic [1:0]          we_a;
    logic [AW-1:0]       addr_a;
    logic [DW-1:0]       din_a;
    logic [1:0]          en_b;
    logic [1:0]          we_b;
    logic [1:0][DW-1:0]  rdata;
    logic                wr_ok;

    assign wr_ok = I_WE && !is_transparent(64'(I_WD), TRANSP_BITS);

    // INIT drives port A of both banks from the sweep counter; the counter's
    // extra MSB marks the last address written. In RUN, port A serves the
    // write bank and port B the read bank. Reads remember which bank they
    // came from so a swap in the same cycle cannot redirect the result.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        wbank_d   = wbank_q;
        ready_d   = ready_q;
        rvalid_d  = 1'b0;
        rd_bank_d = rd_bank_q;
        we_a      = 2'b00;
        addr_a    = sweep_q[AW-1:0];
        din_a     = CLR_VAL;
        en_b      = 2'b00;
        we_b      = 2'b00;
        case (state_q)
            ST_INIT: begin
                we_a    = 2'b11;
                sweep_d = sweep_q + (AW+1)'(1);
                if (sweep_d[AW]) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                addr_a           = I_WADDR;
                din_a            = I_WD;
                we_a[wbank_q]    = wr_ok;
                en_b[~wbank_q]   = I_RE;
                we_b[~wbank_q]   = I_RE && CLEAR_ON_READ;
                rvalid_d         = I_RE;
                rd_bank_d        = ~wbank_q;
                if (I_SWAP) begin
                    wbank_d = ~wbank_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            wbank_q   <= 1'b0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            wbank_q   <= wbank_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dpram #(
            .AW(AW),
            .DW(DW)
        ) u_bank (
            .clk    (I_CLK),
            .a_we   (we_a[b]),
            .a_addr (addr_a),
            .a_wdata(din_a),
            .b_en   (en_b[b]),
            .b_we   (we_b[b]),
            .b_addr (I_RADDR),
            .b_wdata(CLR_VAL),
            .b_rdata(rdata[b])
        );
    end

    // RAM output holds stale data between reads; mask it when not valid.
    assign O_RD     = rvalid_q ? rdata[rd_bank_q] : '0;
    assign O_RVALID = rvalid_q;
    assign O_WBANK  = wbank_q;
    assign O_READY  = ready_q;

endmodule

// File: tb/tb_line_buffer_2bank.sv
// tb_line_buffer_2bank
// Directed bench for line_buffer_2bank. Two instances share all inputs:
// dut_c clears on read, dut_n reads non-destructively.
module tb_line_buffer_2bank;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          swap;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] raddr;

    logic [DW-1:0] rd_c, rd_n;
    logic          rvalid_c, rvalid_n;
    logic          wbank_c, wbank_n;
    logic          ready_c, ready_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_buffer_2bank #(
        .AW(AW), .DW(DW), .CLEAR_ON_READ(1'b1), .CLR_VAL(8'h00), .TRANSP_BITS(2)
    ) dut_c (
        .I_CLK(clk), .I_RST(rst), .I_SWAP(swap), .I_WE(we), .I_WADDR(waddr),
        .I_WD(wd), .I_RE(re), .I_RADDR(raddr), .O_RD(rd_c), .O_RVALID(rvalid_c),
        .O_WBANK(wbank_c), .O_READY(ready_c)
    );

    line_buffer_2bank #(
        .AW(AW), .DW(DW), .CLEAR_ON_READ(1'b0), .CLR_VAL(8'h00), .TRANSP_BITS(2)
    ) dut_n (
        .I_CLK(clk), .I_RST(rst), .I_SWAP(swap), .I_WE(we), .I_WADDR(waddr),
        .I_WD(wd), .I_RE(re), .I_RADDR(raddr), .O_RD(rd_n), .O_RVALID(rvalid_n),
        .O_WBANK(wbank_n), .O_READY(ready_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s_we, input logic [AW-1:0] s_waddr,
                                 input logic [DW-1:0] s_wd, input logic s_re,
                                 input logic [AW-1:0] s_raddr, input logic s_swap);
        we    = s_we;
        waddr = s_waddr;
        wd    = s_wd;
        re    = s_re;
        raddr = s_raddr;
        swap  = s_swap;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRead(input string tag, input logic [DW-1:0] exp_c, input logic [DW-1:0] exp_n);
        checkOutput({tag, "_rvalid_c"}, 16'(rvalid_c), 16'h1);
        checkOutput({tag, "_rvalid_n"}, 16'(rvalid_n), 16'h1);
        checkOutput({tag, "_rd_c"}, 16'(rd_c), 16'(exp_c));
        checkOutput({tag, "_rd_n"}, 16'(rd_n), 16'(exp_n));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rvalid_c"}, 16'(rvalid_c), 16'h0);
        checkOutput({tag, "_rvalid_n"}, 16'(rvalid_n), 16'h0);
        checkOutput({tag, "_rd_c"}, 16'(rd_c), 16'h0);
        checkOutput({tag, "_rd_n"}, 16'(rd_n), 16'h0);
    endtask

    task automatic checkBank(input string tag, input logic exp);
        checkOutput({tag, "_wbank_c"}, 16'(wbank_c), 16'(exp));
        checkOutput({tag, "_wbank_n"}, 16'(wbank_n), 16'(exp));
    endtask

    task automatic checkReady(input string tag, input logic exp);
        checkOutput({tag, "_ready_c"}, 16'(ready_c), 16'(exp));
        checkOutput({tag, "_ready_n"}, 16'(ready_n), 16'(exp));
    endtask

    initial begin
        rst = 1'b1; swap = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; wd = '0; raddr = '0;
        repeat (3) tick();
        checkReady("reset", 1'b0);
        checkBank("reset", 1'b0);
        checkIdle("reset");

        // Sweep with all strobes held high; they must be ignored.
        rst = 1'b0; we = 1'b1; re = 1'b1; swap = 1'b1;
        waddr = 9'd5; wd = 8'hFF; raddr = 9'd5;
        repeat (511) tick();
        checkReady("sweep_511", 1'b0);
        checkBank("sweep_511", 1'b0);
        checkIdle("sweep_511");
        tick();
        checkReady("sweep_512", 1'b1);
        checkBank("sweep_512", 1'b0);

        // Both banks read back as cleared.
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd5, 1'b0);
        checkRead("clr_b1_a5", 8'h00, 8'h00);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h1FF, 1'b0);
        checkRead("clr_b1_a1ff", 8'h00, 8'h00);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("swap1", 1'b1);
        checkIdle("swap1");
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd5, 1'b0);
        checkRead("clr_b0_a5", 8'h00, 8'h00);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h1FF, 1'b1);
        checkRead("clr_b0_a1ff", 8'h00, 8'h00);
        checkBank("swap2", 1'b0);

        // Basic double buffer.
        applyStimulus(1'b1, 9'h010, 8'h5D, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("db_swap", 1'b1);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h010, 1'b0);
        checkRead("db_rd1", 8'h5D, 8'h5D);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h010, 1'b0);
        checkRead("db_rd2", 8'h00, 8'h5D);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b0);
        checkIdle("db_idle");

        // Transparency: 0x4C dropped, 0x4D kept.
        applyStimulus(1'b1, 9'd3, 8'h4C, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("tr_swap1", 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd3, 1'b0);
        checkRead("tr_4c", 8'h00, 8'h00);
        applyStimulus(1'b1, 9'd3, 8'h4D, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b1, 9'd7, 8'h33, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("tr_swap2", 1'b1);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd3, 1'b0);
        checkRead("tr_4d", 8'h4D, 8'h4D);

        // Write, read and swap together on address 7.
        applyStimulus(1'b1, 9'd7, 8'hA1, 1'b1, 9'd7, 1'b1);
        checkRead("col_old", 8'h33, 8'h33);
        checkBank("col_swap", 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd7, 1'b0);
        checkRead("col_new", 8'hA1, 8'hA1);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd7, 1'b0);
        checkRead("col_again", 8'h00, 8'hA1);

        // Back-to-back swaps.
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("b2b_1", 1'b1);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("b2b_2", 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("b2b_3", 1'b1);

        // Repeated reads of 0x1FF.
        applyStimulus(1'b1, 9'h1FF, 8'h6E, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b1);
        checkBank("nd_swap", 1'b0);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h1FF, 1'b0);
        checkRead("nd_rd1", 8'h6E, 8'h6E);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b0);
        checkIdle("nd_gap1");
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h1FF, 1'b0);
        checkRead("nd_rd2", 8'h00, 8'h6E);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b0);
        checkIdle("nd_gap2");
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h1FF, 1'b0);
        checkRead("nd_rd3", 8'h00, 8'h6E);

        // Reset in RUN with a read and swap on the same edge.
        rst = 1'b1;
        applyStimulus(1'b1, 9'd1, 8'h11, 1'b1, 9'h1FF, 1'b1);
        checkReady("rst_run", 1'b0);
        checkBank("rst_run", 1'b0);
        checkIdle("rst_run");
        rst = 1'b0;
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 1'b0);
        repeat (99) tick();
        checkReady("sweep100", 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (511) tick();
        checkReady("resweep_511", 1'b0);
        checkBank("resweep_511", 1'b0);
        tick();
        checkReady("resweep_512", 1'b1);

        // Sweep cleared everything written earlier.
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h1FF, 1'b1);
        checkRead("post_b1_1ff", 8'h00, 8'h00);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'h010, 1'b0);
        checkRead("post_b0_10", 8'h00, 8'h00);
        applyStimulus(1'b0, 9'd0, 8'h00, 1'b1, 9'd3, 1'b0);
        checkRead("post_b0_3", 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
